// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three-port arbiter (instruction, CPU data, DMA) onto one SDRAM controller port.
// Fixed priority DATA > INSTR > DMA; define SDRAM_ARB_ROUND_ROBIN_EN for round robin.
module sdram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        data_m_access,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  input  logic [19:1] dma_m_addr,
  input  logic [15:0] dma_m_data_out,
  input  logic        dma_m_wr_en,
  input  logic [1:0]  dma_m_bytesel,
  input  logic        dma_m_access,
  output logic        dma_m_ack,
  output logic [15:0] dma_m_data_in,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_m_access,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {G_NONE, G_INSTR, G_DATA, G_DMA} grant_t;
  state_t state, state_nxt;
  grant_t grant, grant_nxt, winner;
  logic done;
  assign done = state == BUSY && q_m_ack;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      grant <= G_NONE;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // last holds the most recently completed grantee, which drops to lowest priority
  grant_t last;
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= G_INSTR;
    else if (done) last <= grant;
  always_comb
    case (last)
      G_DATA:  winner = dma_m_access ? G_DMA : instr_m_access ? G_INSTR : data_m_access ? G_DATA : G_NONE;
      G_DMA:   winner = instr_m_access ? G_INSTR : data_m_access ? G_DATA : dma_m_access ? G_DMA : G_NONE;
      default: winner = data_m_access ? G_DATA : dma_m_access ? G_DMA : instr_m_access ? G_INSTR : G_NONE;
    endcase
`else
  always_comb winner = data_m_access ? G_DATA : instr_m_access ? G_INSTR : dma_m_access ? G_DMA : G_NONE;
`endif
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    if (state == IDLE && winner != G_NONE) begin
      state_nxt = BUSY;
      grant_nxt = winner;
    end else if (done) begin
      state_nxt = IDLE;
      grant_nxt = G_NONE;
    end
  end
  // grant is NONE whenever IDLE, so muxing on grant alone zeroes the bus in IDLE
  always_comb begin
    q_m_access      = state == BUSY;
    q_m_addr        = grant == G_INSTR ? instr_m_addr : grant == G_DATA ? data_m_addr : grant == G_DMA ? dma_m_addr : '0;
    q_m_data_out    = grant == G_DATA ? data_m_data_out : grant == G_DMA ? dma_m_data_out : '0;
    q_m_wr_en       = grant == G_DATA ? data_m_wr_en : grant == G_DMA && dma_m_wr_en;
    q_m_bytesel     = grant == G_INSTR ? 2'b11 : grant == G_DATA ? data_m_bytesel : grant == G_DMA ? dma_m_bytesel : 2'b00;
    instr_m_ack     = done && grant == G_INSTR;
    data_m_ack      = done && grant == G_DATA;
    dma_m_ack       = done && grant == G_DMA;
    instr_m_data_in = grant == G_INSTR ? q_m_data_in : '0;
    data_m_data_in  = grant == G_DATA ? q_m_data_in : '0;
    dma_m_data_in   = grant == G_DMA ? q_m_data_in : '0;
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_sdram_arbiter;
  localparam logic [1:0] G_NONE = 2'd0, G_INSTR = 2'd1, G_DATA = 2'd2, G_DMA = 2'd3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [19:1] instr_m_addr = '0;
  logic instr_m_access = 1'b0;
  logic instr_m_ack;
  logic [15:0] instr_m_data_in;
  logic [19:1] data_m_addr = '0;
  logic [15:0] data_m_data_out = '0;
  logic data_m_wr_en = 1'b0;
  logic [1:0] data_m_bytesel = '0;
  logic data_m_access = 1'b0;
  logic data_m_ack;
  logic [15:0] data_m_data_in;
  logic [19:1] dma_m_addr = '0;
  logic [15:0] dma_m_data_out = '0;
  logic dma_m_wr_en = 1'b0;
  logic [1:0] dma_m_bytesel = '0;
  logic dma_m_access = 1'b0;
  logic dma_m_ack;
  logic [15:0] dma_m_data_in;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic q_m_wr_en;
  logic [1:0] q_m_bytesel;
  logic q_m_access;
  logic q_m_ack = 1'b0;
  logic [15:0] q_m_data_in = '0;

  sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access), .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out), .data_m_wr_en(data_m_wr_en), .data_m_bytesel(data_m_bytesel),
    .data_m_access(data_m_access), .data_m_ack(data_m_ack), .data_m_data_in(data_m_data_in),
    .dma_m_addr(dma_m_addr), .dma_m_data_out(dma_m_data_out), .dma_m_wr_en(dma_m_wr_en), .dma_m_bytesel(dma_m_bytesel),
    .dma_m_access(dma_m_access), .dma_m_ack(dma_m_ack), .dma_m_data_in(dma_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_data_in(q_m_data_in)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: whether a transaction is open, who owns it, and who finished last.
  logic m_busy;
  logic [1:0] m_grant, m_last;

  function automatic logic [1:0] pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] ord [3];
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic [1:0] cyc [3];
    int s;
    cyc[0] = G_DATA; cyc[1] = G_DMA; cyc[2] = G_INSTR;
    s = 0;
    for (int k = 0; k < 3; k++) if (cyc[k] == last) s = k + 1;
    for (int k = 0; k < 3; k++) ord[k] = cyc[(s + k) % 3];
`else
    ord[0] = G_DATA; ord[1] = G_INSTR; ord[2] = G_DMA;
    if (last == 2'bxx) return G_NONE;
`endif
    for (int k = 0; k < 3; k++) if (req[ord[k]]) return ord[k];
    return G_NONE;
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_busy <= 1'b0;
      m_grant <= G_NONE;
      m_last <= G_INSTR;
    end else if (!m_busy) begin
      if (pick(m_last, {dma_m_access, data_m_access, instr_m_access, 1'b0}) != G_NONE) begin
        m_busy <= 1'b1;
        m_grant <= pick(m_last, {dma_m_access, data_m_access, instr_m_access, 1'b0});
      end
    end else if (q_m_ack) begin
      m_busy <= 1'b0;
      m_last <= m_grant;
      m_grant <= G_NONE;
    end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) if (chk_en) begin
    logic fin;
    fin = m_busy && q_m_ack;
    chk("q_access", q_m_access, m_busy);
    case (m_grant)
      G_INSTR: begin
        chk("q_addr", q_m_addr, instr_m_addr); chk("q_dout", q_m_data_out, 0);
        chk("q_wr", q_m_wr_en, 0); chk("q_bsel", q_m_bytesel, 3);
      end
      G_DATA: begin
        chk("q_addr", q_m_addr, data_m_addr); chk("q_dout", q_m_data_out, data_m_data_out);
        chk("q_wr", q_m_wr_en, data_m_wr_en); chk("q_bsel", q_m_bytesel, data_m_bytesel);
      end
      G_DMA: begin
        chk("q_addr", q_m_addr, dma_m_addr); chk("q_dout", q_m_data_out, dma_m_data_out);
        chk("q_wr", q_m_wr_en, dma_m_wr_en); chk("q_bsel", q_m_bytesel, dma_m_bytesel);
      end
      default: begin
        chk("q_addr", q_m_addr, 0); chk("q_dout", q_m_data_out, 0);
        chk("q_wr", q_m_wr_en, 0); chk("q_bsel", q_m_bytesel, 0);
      end
    endcase
    chk("instr_ack", instr_m_ack, fin && m_grant == G_INSTR);
    chk("data_ack", data_m_ack, fin && m_grant == G_DATA);
    chk("dma_ack", dma_m_ack, fin && m_grant == G_DMA);
    chk("instr_din", instr_m_data_in, m_grant == G_INSTR ? q_m_data_in : 16'h0);
    chk("data_din", data_m_data_in, m_grant == G_DATA ? q_m_data_in : 16'h0);
    chk("dma_din", dma_m_data_in, m_grant == G_DMA ? q_m_data_in : 16'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_m_access = 0; data_m_access = 0; dma_m_access = 0;
    data_m_wr_en = 0; dma_m_wr_en = 0; data_m_bytesel = 0; dma_m_bytesel = 0;
    data_m_data_out = 0; dma_m_data_out = 0; q_m_ack = 0; q_m_data_in = 0;
  endtask

  logic [19:1] got [4];
  int idle_cnt [4];

  // Serves n transactions with one ack each; optionally the served port then withdraws.
  task automatic serve(input int n, input bit drop);
    for (int t = 0; t < n; t++) begin
      int w;
      w = 0;
      while (!q_m_access && w < 20) begin tick(); w++; end
      idle_cnt[t] = w;
      got[t] = q_m_addr;
      q_m_ack = 1; q_m_data_in = 16'($urandom);
      tick();
      q_m_ack = 0;
      if (drop) begin
        if (got[t] == instr_m_addr) instr_m_access = 0;
        if (got[t] == data_m_addr) data_m_access = 0;
        if (got[t] == dma_m_addr) dma_m_access = 0;
      end
    end
  endtask

  initial begin
    #2 reset = 1;
    #1;
    chk("rst_access", q_m_access, 0);
    chk("rst_acks", {instr_m_ack, data_m_ack, dma_m_ack}, 0);
    chk("rst_addr", q_m_addr, 0);
    chk("rst_bsel", q_m_bytesel, 0);
    tick(); tick();
    reset = 0;
    chk_en = 1;
    tick();

    // single instruction read
    instr_m_addr = 19'h00100; instr_m_access = 1;
    #3 chk("rd_idle_access", q_m_access, 0);
    tick();
    #3 chk("rd_busy_access", q_m_access, 1);
    chk("rd_addr", q_m_addr, 19'h00100);
    chk("rd_bsel", q_m_bytesel, 2'b11);
    tick(); tick();
    q_m_ack = 1; q_m_data_in = 16'hBEEF;
    #3 chk("rd_ack", instr_m_ack, 1);
    chk("rd_din", instr_m_data_in, 16'hBEEF);
    tick();
    q_m_ack = 0; instr_m_access = 0;
    #3 chk("rd_ack_gone", instr_m_ack, 0);
    chk("rd_access_gone", q_m_access, 0);
    tick();

    // three simultaneous requesters
    instr_m_addr = 19'h11111; data_m_addr = 19'h22222; dma_m_addr = 19'h33333;
    instr_m_access = 1; data_m_access = 1; dma_m_access = 1;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    serve(4, 0);
    chk("rr_g0", got[0], 19'h22222); chk("rr_g1", got[1], 19'h33333);
    chk("rr_g2", got[2], 19'h11111); chk("rr_g3", got[3], 19'h22222);
    for (int k = 1; k < 4; k++) chk("rr_gap", idle_cnt[k], 1);
`else
    serve(3, 1);
    chk("fp_g0", got[0], 19'h22222); chk("fp_g1", got[1], 19'h11111); chk("fp_g2", got[2], 19'h33333);
    for (int k = 1; k < 3; k++) chk("fp_gap", idle_cnt[k], 1);
`endif
    clear_inputs();
    tick(); tick();

    // data write
    data_m_addr = 19'h0ABCD; data_m_data_out = 16'h1234; data_m_wr_en = 1; data_m_bytesel = 2'b01; data_m_access = 1;
    tick();
    #3 chk("wr_en", q_m_wr_en, 1);
    chk("wr_bsel", q_m_bytesel, 2'b01);
    chk("wr_dout", q_m_data_out, 16'h1234);
    q_m_ack = 1;
    #1 chk("wr_ack", data_m_ack, 1);
    chk("wr_other_acks", {instr_m_ack, dma_m_ack}, 0);
    tick();
    clear_inputs();
    tick();

    // reset during DMA transaction
    dma_m_addr = 19'h00F00; dma_m_access = 1;
    tick();
    #2 chk("dma_busy", q_m_access, 1);
    reset = 1;
    #1 chk("dma_rst_access", q_m_access, 0);
    reset = 0; dma_m_access = 0; q_m_ack = 1;
    #1 chk("dma_rst_ack", dma_m_ack, 0);
    tick();
    #3 chk("dma_after_ack", dma_m_ack, 0);
    chk("dma_after_access", q_m_access, 0);
    q_m_ack = 0;
    tick();

    // stray ack in IDLE
    q_m_ack = 1;
    #3 chk("stray_acks", {instr_m_ack, data_m_ack, dma_m_ack}, 0);
    tick();
    #3 chk("stray_access", q_m_access, 0);
    q_m_ack = 0;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      instr_m_access = $urandom_range(0, 1) == 1;
      data_m_access = $urandom_range(0, 2) == 0;
      dma_m_access = $urandom_range(0, 1) == 1;
      instr_m_addr = 19'($urandom); data_m_addr = 19'($urandom); dma_m_addr = 19'($urandom);
      data_m_data_out = 16'($urandom); dma_m_data_out = 16'($urandom);
      data_m_wr_en = 1'($urandom); dma_m_wr_en = 1'($urandom);
      data_m_bytesel = 2'($urandom); dma_m_bytesel = 2'($urandom);
      q_m_ack = $urandom_range(0, 2) == 0;
      q_m_data_in = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
        #1 reset = 0;
      end
      tick();
    end
    clear_inputs();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
